// File: rtl/l2_req_arb.sv
// l2_req_arb: per-channel round-robin request arbiter with credit
// limiting and per-stream L2 response return.
module l2_req_arb #(
  parameter int nstrms     = 64,
  parameter int channels   = 4,
  parameter int spc        = nstrms / channels,
  parameter int lsid_width = (spc > 1) ? $clog2(spc) : 1,
  parameter int max_out    = 4,
  parameter int cnt_width  = $clog2(max_out + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [nstrms-1:0]              i_req_v,
  output logic [nstrms-1:0]              i_req_r,
  output logic [channels-1:0]            o_l2_v,
  input  logic [channels-1:0]            o_l2_r,
  output logic [channels*lsid_width-1:0] o_l2_lsid,
  input  logic [channels-1:0]            i_l2_v,
  output logic [channels-1:0]            i_l2_r,
  input  logic [channels*lsid_width-1:0] i_l2_lsid,
  output logic [nstrms-1:0]              o_rsp_v,
  input  logic [nstrms-1:0]              o_rsp_r,
  output logic [channels-1:0]            o_err
);

  localparam int lw = lsid_width;
  localparam int cw = cnt_width;
  localparam logic [cw-1:0] max_cnt = cw'(max_out);
  localparam logic [lw-1:0] last_id = lw'(spc - 1);
  localparam logic [lw:0]   spc_w   = (lw + 1)'(spc);

  for (genvar c = 0; c < channels; c++) begin : g_ch
    logic [spc-1:0] rv;
    logic [spc-1:0] rsp_r;
    logic [spc-1:0] grant;
    logic [spc-1:0] rsp_v;
    logic           rq_v;
    logic           rs_v;
    logic           err;
    logic           found;
    logic           can_issue;
    logic           req_fire;
    logic           rsp_fire;
    logic           acc;
    logic [lw-1:0]  rq_lsid;
    logic [lw-1:0]  rs_lsid;
    logic [lw-1:0]  rr;
    logic [lw-1:0]  win;
    logic [lw-1:0]  rr_nxt;
    logic [cw-1:0]  cnt;

    assign rv    = i_req_v[c*spc +: spc];
    assign rsp_r = o_rsp_r[c*spc +: spc];

    // Scan from the far end so the lowest offset from rr wins last.
    always_comb begin
      logic [lw:0] idx;
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = spc - 1; k >= 0; k--) begin
        idx = {1'b0, rr} + (lw + 1)'(k);
        if (idx >= spc_w) idx = idx - spc_w;
        if (rv[idx[lw-1:0]]) begin
          found = 1'b1;
          win   = idx[lw-1:0];
        end
      end
    end

    assign can_issue = reset && (cnt < max_cnt)
                     && (!rq_v || o_l2_r[c]);
    assign req_fire  = can_issue && found;
    assign rr_nxt    = (win == last_id) ? '0 : win + 1'b1;

    always_comb begin
      grant = '0;
      if (req_fire) grant[win] = 1'b1;
    end

    assign rsp_fire  = rs_v && rsp_r[rs_lsid];
    assign i_l2_r[c] = reset && (!rs_v || rsp_fire);
    assign acc       = i_l2_v[c] && i_l2_r[c];

    always_comb begin
      rsp_v = '0;
      if (rs_v) rsp_v[rs_lsid] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rq_v    <= 1'b0;
        rq_lsid <= '0;
        rs_v    <= 1'b0;
        rs_lsid <= '0;
        rr      <= '0;
        cnt     <= '0;
        err     <= 1'b0;
      end else begin
        if (req_fire) begin
          rq_v    <= 1'b1;
          rq_lsid <= win;
          rr      <= rr_nxt;
        end else if (o_l2_r[c]) begin
          rq_v <= 1'b0;
        end
        if (acc) begin
          rs_v    <= 1'b1;
          rs_lsid <= i_l2_lsid[c*lw +: lw];
        end else if (rsp_fire) begin
          rs_v <= 1'b0;
        end
        // A consume with nothing outstanding is a protocol error.
        if (req_fire && !rsp_fire) begin
          cnt <= cnt + 1'b1;
        end else if (rsp_fire && !req_fire) begin
          if (cnt == '0) err <= 1'b1;
          else           cnt <= cnt - 1'b1;
        end
      end
    end

    assign i_req_r[c*spc +: spc]  = grant;
    assign o_rsp_v[c*spc +: spc]  = rsp_v;
    assign o_l2_v[c]              = rq_v;
    assign o_l2_lsid[c*lw +: lw]  = rq_lsid;
    assign o_err[c]               = err;
  end

endmodule

// File: tb/tb_l2_req_arb.sv
// tb_l2_req_arb: random traffic against a transaction-level model
// with an in-order L2 memory that returns granted cachelines.
module tb_l2_req_arb;

  localparam int NS  = 64;
  localparam int CH  = 4;
  localparam int SPC = 16;
  localparam int LW  = 4;
  localparam int MO  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [NS-1:0] i_req_v, i_req_r;
  logic [CH-1:0] o_l2_v, o_l2_r;
  logic [15:0]   o_l2_lsid, i_l2_lsid;
  logic [CH-1:0] i_l2_v, i_l2_r;
  logic [NS-1:0] o_rsp_v, o_rsp_r;
  logic [CH-1:0] o_err;

  l2_req_arb #(
    .nstrms(NS), .channels(CH), .max_out(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_v(i_req_v), .i_req_r(i_req_r),
    .o_l2_v(o_l2_v), .o_l2_r(o_l2_r),
    .o_l2_lsid(o_l2_lsid),
    .i_l2_v(i_l2_v), .i_l2_r(i_l2_r),
    .i_l2_lsid(i_l2_lsid),
    .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r),
    .o_err(o_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int m_rr[CH], m_cnt[CH], m_rql[CH], m_rsl[CH];
  int f_win[CH];
  bit m_rqv[CH], m_rsv[CH], m_err[CH];
  bit f_req[CH], f_cons[CH], f_acc[CH], from_mem[CH];
  int memq[CH][256];
  int mh[CH], mt[CH];

  logic [63:0] e_req_r, e_rsp_v;
  logic [3:0]  e_l2_v, e_l2_r, e_err;
  logic [15:0] e_l2_lsid;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_rr[c] = 0; m_cnt[c] = 0;
      m_rql[c] = 0; m_rsl[c] = 0;
      m_rqv[c] = 0; m_rsv[c] = 0; m_err[c] = 0;
      mh[c] = 0; mt[c] = 0;
    end
  endtask

  task automatic eval();
    e_req_r = '0; e_rsp_v = '0;
    e_l2_v = '0; e_l2_r = '0; e_err = '0;
    e_l2_lsid = '0;
    for (int c = 0; c < CH; c++) begin
      bit can, found;
      int w;
      can = reset && (m_cnt[c] < MO)
          && (!m_rqv[c] || o_l2_r[c]);
      found = 0;
      w = 0;
      for (int k = 0; k < SPC; k++) begin
        int s;
        s = (m_rr[c] + k) % SPC;
        if (!found && i_req_v[c*SPC+s]) begin
          found = 1;
          w = s;
        end
      end
      f_req[c] = found && can;
      f_win[c] = w;
      if (f_req[c]) e_req_r[c*SPC+w] = 1'b1;
      e_l2_v[c] = m_rqv[c];
      e_l2_lsid[c*LW +: LW] = LW'(m_rql[c]);
      f_cons[c] = m_rsv[c] && o_rsp_r[c*SPC+m_rsl[c]];
      e_l2_r[c] = reset && (!m_rsv[c] || f_cons[c]);
      f_acc[c] = i_l2_v[c] && e_l2_r[c];
      if (m_rsv[c]) e_rsp_v[c*SPC+m_rsl[c]] = 1'b1;
      e_err[c] = m_err[c];
    end
  endtask

  task automatic step();
    for (int c = 0; c < CH; c++) begin
      if (m_rqv[c] && o_l2_r[c]) begin
        memq[c][mt[c] % 256] = m_rql[c];
        mt[c]++;
      end
      if (f_req[c]) begin
        m_rqv[c] = 1;
        m_rql[c] = f_win[c];
        m_rr[c]  = (f_win[c] + 1) % SPC;
      end else if (o_l2_r[c]) begin
        m_rqv[c] = 0;
      end
      if (f_acc[c]) begin
        m_rsv[c] = 1;
        m_rsl[c] = int'(i_l2_lsid[c*LW +: LW]);
        if (from_mem[c]) mh[c]++;
      end else if (f_cons[c]) begin
        m_rsv[c] = 0;
      end
      if (f_req[c] && !f_cons[c]) begin
        m_cnt[c]++;
      end else if (f_cons[c] && !f_req[c]) begin
        if (m_cnt[c] == 0) m_err[c] = 1;
        else               m_cnt[c]--;
      end
    end
  endtask

  task automatic drive(input int cyc, input bit spur);
    int mode;
    mode = (cyc / 250) % 3;
    case (mode)
      0: i_req_v = {$urandom, $urandom};
      1: i_req_v = {$urandom, $urandom}
                 & {$urandom, $urandom}
                 & {$urandom, $urandom};
      default: i_req_v = 64'h0002_0000_0001_8021;
    endcase
    if (mode == 1) begin
      o_l2_r  = 4'($urandom);
      o_rsp_r = {$urandom, $urandom};
    end else begin
      o_l2_r  = 4'($urandom | $urandom);
      o_rsp_r = {$urandom, $urandom}
              | {$urandom, $urandom};
    end
    for (int c = 0; c < CH; c++) begin
      from_mem[c] = 0;
      i_l2_lsid[c*LW +: LW] = 4'($urandom);
      i_l2_v[c] = 1'b0;
      if (mh[c] != mt[c] && $urandom % 3 != 0) begin
        i_l2_v[c] = 1'b1;
        i_l2_lsid[c*LW +: LW] = 4'(memq[c][mh[c] % 256]);
        from_mem[c] = 1;
      end else if (spur && mh[c] == mt[c]
                   && m_cnt[c] == 0
                   && $urandom % 8 == 0) begin
        i_l2_v[c] = 1'b1;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    i_req_v = '0; o_l2_r = '0;
    i_l2_v = '0; i_l2_lsid = '0;
    o_rsp_r = '0;
    model_reset();
    for (int cyc = 0; cyc < 3200; cyc++) begin
      @(negedge clk);
      reset = (cyc >= 3) && !(cyc >= 2000 && cyc < 2003);
      drive(cyc, cyc >= 1500 && cyc < 2000);
      if (!reset) model_reset();
      #1;
      eval();
      chk("i_req_r", i_req_r, e_req_r);
      chk("o_l2_v", 64'(o_l2_v), 64'(e_l2_v));
      chk("o_l2_lsid", 64'(o_l2_lsid), 64'(e_l2_lsid));
      chk("i_l2_r", 64'(i_l2_r), 64'(e_l2_r));
      chk("o_rsp_v", o_rsp_v, e_rsp_v);
      chk("o_err", 64'(o_err), 64'(e_err));
      @(posedge clk);
      if (reset) step();
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
